// File: rtl/up_cntr_pkg.sv
// Shared definitions for the trigger-gated up counter: default width and the
// named states of the default 2-bit configuration.
package up_cntr_pkg;

    localparam int UP_CNTR_W = 2;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } up_cntr_state_e;

endpackage

// File: rtl/up_cntr.sv
// Trigger-gated modulo-2^CNT_W up counter built as a Moore FSM; the state register is the count.
// Optional feature macro UP_CNTR_WRAP_EN adds a registered one-cycle wrap pulse output.
module up_cntr
    import up_cntr_pkg::*;
#(
    parameter int CNT_W = UP_CNTR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trigger,
    output logic [CNT_W-1:0] state
`ifdef UP_CNTR_WRAP_EN
    ,
    output logic             wrap
`endif
);

    localparam logic [CNT_W-1:0] RST_STATE = CNT_W'(S0);
    localparam logic [CNT_W-1:0] LAST_STATE = '1;

    logic [CNT_W-1:0] state_q;
    logic [CNT_W-1:0] state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Increment naturally wraps the all-ones state back to S0.
    always_comb begin
        state_d = state_q;
        if (trigger) begin
            state_d = state_q + 1'b1;
        end
    end

    assign state = state_q;

`ifdef UP_CNTR_WRAP_EN
    logic wrap_q;
    logic wrap_d;

    always_comb begin
        wrap_d = 1'b0;
        if (trigger && (state_q == LAST_STATE)) begin
            wrap_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;
`endif

endmodule

// File: tb/tb_up_cntr.sv
// Self-checking bench for up_cntr: default 2-bit and a 3-bit instance share
// stimulus; expected results flow through a scoreboard queue.
`timescale 1ns/1ps
module tb_up_cntr;

    logic       clk;
    logic       reset;
    logic       trigger;
    logic [1:0] state2;
    logic [2:0] state3;
`ifdef UP_CNTR_WRAP_EN
    logic       wrap2;
    logic       wrap3;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [1:0] s2;
        logic [2:0] s3;
        logic       w2;
        logic       w3;
    } exp_t;

    exp_t sb[$];

    // Bench-side reference state of both counters.
    logic [1:0] m2;
    logic [2:0] m3;

    up_cntr u_dut2 (
        .clk    (clk),
        .reset  (reset),
        .trigger(trigger),
        .state  (state2)
`ifdef UP_CNTR_WRAP_EN
        ,
        .wrap   (wrap2)
`endif
    );

    up_cntr #(.CNT_W(3)) u_dut3 (
        .clk    (clk),
        .reset  (reset),
        .trigger(trigger),
        .state  (state3)
`ifdef UP_CNTR_WRAP_EN
        ,
        .wrap   (wrap3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pop one expected entry and compare against the DUT outputs.
    task automatic pop_and_compare(input bit chk3);
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: actual size 0, required >0");
            return;
        end
        e = sb.pop_front();
        checks++;
        if (state2 !== e.s2) begin
            errors++;
            $display("FAIL %s state(W=2): actual %0d required %0d", e.name, state2, e.s2);
        end
        if (chk3) begin
            checks++;
            if (state3 !== e.s3) begin
                errors++;
                $display("FAIL %s state(W=3): actual %0d required %0d", e.name, state3, e.s3);
            end
        end
`ifdef UP_CNTR_WRAP_EN
        checks++;
        if (wrap2 !== e.w2) begin
            errors++;
            $display("FAIL %s wrap(W=2): actual %0b required %0b", e.name, wrap2, e.w2);
        end
        if (chk3) begin
            checks++;
            if (wrap3 !== e.w3) begin
                errors++;
                $display("FAIL %s wrap(W=3): actual %0b required %0b", e.name, wrap3, e.w3);
            end
        end
`endif
    endtask

    // Drive one cycle of inputs, predict, then check just after the edge.
    task automatic step(input string name, input logic rst, input logic trig);
        exp_t e;
        reset   = rst;
        trigger = trig;
        e.name = name;
        e.w2   = !rst && trig && (m2 == 2'd3);
        e.w3   = !rst && trig && (m3 == 3'd7);
        if (rst) begin
            m2 = 2'd0;
            m3 = 3'd0;
        end else if (trig) begin
            m2 = (m2 == 2'd3) ? 2'd0 : m2 + 2'd1;
            m3 = (m3 == 3'd7) ? 3'd0 : m3 + 3'd1;
        end
        e.s2 = m2;
        e.s3 = m3;
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_and_compare(1'b1);
    endtask

    task automatic test_reset();
        exp_t e;
        logic [1:0] seq2 [5];
        seq2 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        reset   = 1'b0;
        trigger = 1'b1;
        #13 reset = 1'b1;
        e = '{name: "reset", s2: 2'd0, s3: 3'd0, w2: 1'b0, w3: 1'b0};
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_and_compare(1'b1);
        #6 reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            e = '{name: "count_after_reset", s2: seq2[k], s3: 3'(k + 1), w2: (k == 3), w3: 1'b0};
            sb.push_back(e);
            @(posedge clk);
            #1;
            pop_and_compare(1'b1);
        end
        m2 = 2'd1;
        m3 = 3'd5;
    endtask

    task automatic test_hold();
        while (m2 != 2'd2) step("hold_setup", 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step("hold", 1'b0, 1'b0);
        step("hold_resume", 1'b0, 1'b1);
    endtask

    task automatic test_reset_priority();
        while (m2 != 2'd3) step("prio_setup", 1'b0, 1'b1);
        step("reset_priority", 1'b1, 1'b1);
        step("reset_held", 1'b1, 1'b1);
        step("reset_held", 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        while (m2 != 2'd1) step("mid_setup", 1'b0, 1'b1);
        step("reset_mid", 1'b1, 1'b1);
        step("resume_1", 1'b0, 1'b1);
        step("resume_2", 1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        while (m2 != 2'd3) step("wrap_setup", 1'b0, 1'b1);
        step("wrap_idle_last", 1'b0, 1'b0);
        step("wrap_idle_last", 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) step("wrap_run", 1'b0, 1'b1);
    endtask

    task automatic test_cntw3();
        step("w3_reset", 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) step("w3_count", 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 40; k++) begin
            step("random", ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_reset_priority();
        test_reset_mid();
        test_wrap();
        test_cntw3();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: actual time %0t, required completion before it", $time);
        $fatal(1, "timeout");
    end

endmodule
